// File: rtl/shift_pattern_checker.sv
// Bounce-pattern checker: decodes the 10-bit symmetric LED pattern into a ring
// position/direction, tracks the centre-edge-centre sequence and counts violations.
module shift_pattern_checker (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [9:0] pattern,
  output logic [2:0] position,
  output logic       direction,
  output logic       locked,
  output logic       error,
  output logic [7:0] error_count,
  output logic [7:0] loop_count
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_pos;
  logic       r_dir;
  logic       r_locked;
  logic       r_error;
  logic [7:0] r_ecnt;
  logic [7:0] r_lcnt;

  state_t     w_state_nxt;
  logic [2:0] w_pos_nxt;
  logic       w_dir_nxt;
  logic       w_err_nxt;
  logic [7:0] w_ecnt_nxt;
  logic [7:0] w_lcnt_nxt;

  logic       w_legal;
  logic [2:0] w_q;
  logic [2:0] w_pred;

  always_comb begin
    w_legal = 1'b1;
    w_q     = '0;
    case (pattern)
      10'b0000110000: w_q = 3'd0;
      10'b0001001000: w_q = 3'd1;
      10'b0010000100: w_q = 3'd2;
      10'b0100000010: w_q = 3'd3;
      10'b1000000001: w_q = 3'd4;
      default:        w_legal = 1'b0;
    endcase
  end

  // The ends of the ring always reflect, regardless of the stored direction.
  always_comb begin
    if (r_pos == 3'd4)      w_pred = 3'd3;
    else if (r_pos == 3'd0) w_pred = 3'd1;
    else if (r_dir)         w_pred = r_pos + 3'd1;
    else                    w_pred = r_pos - 3'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir;
    w_err_nxt   = 1'b0;
    w_ecnt_nxt  = r_ecnt;
    w_lcnt_nxt  = r_lcnt;
    if (sample_en) begin
      case (r_state)
        HUNT: begin
          if (w_legal) begin
            w_state_nxt = ACQUIRE;
            w_pos_nxt   = w_q;
          end
        end
        ACQUIRE: begin
          if (!w_legal) begin
            w_state_nxt = HUNT;
          end else begin
            w_pos_nxt = w_q;
            if (w_q == r_pos + 3'd1) begin
              w_state_nxt = LOCKED;
              w_dir_nxt   = 1'b1;
            end else if (w_q == r_pos - 3'd1) begin
              w_state_nxt = LOCKED;
              w_dir_nxt   = 1'b0;
            end
          end
        end
        LOCKED: begin
          if (w_legal && (w_q == w_pred)) begin
            w_pos_nxt = w_q;
            w_dir_nxt = (w_q > r_pos);
            if (w_q == 3'd0) w_lcnt_nxt = r_lcnt + 8'd1;
          end else begin
            w_err_nxt = 1'b1;
            if (r_ecnt != '1) w_ecnt_nxt = r_ecnt + 8'd1;
            if (w_legal) begin
              w_state_nxt = ACQUIRE;
              w_pos_nxt   = w_q;
            end else begin
              w_state_nxt = HUNT;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= HUNT;
      r_pos    <= '0;
      r_dir    <= 1'b0;
      r_locked <= 1'b0;
      r_error  <= 1'b0;
      r_ecnt   <= '0;
      r_lcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pos    <= w_pos_nxt;
      r_dir    <= w_dir_nxt;
      r_locked <= (w_state_nxt == LOCKED);
      r_error  <= w_err_nxt;
      r_ecnt   <= w_ecnt_nxt;
      r_lcnt   <= w_lcnt_nxt;
    end
  end

  assign position    = r_pos;
  assign direction   = r_dir;
  assign locked      = r_locked;
  assign error       = r_error;
  assign error_count = r_ecnt;
  assign loop_count  = r_lcnt;

endmodule
